// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised pipeline stage register with a valid/ready handshake and a
//   2-entry skid buffer. It carries one packed control bus and one packed data
//   bus per entry. Throughput is one entry per cycle while in_ready is a pure
//   function of registered state. A synchronous flush squashes everything
//   held to a bubble.
//
// Ports
//   Clk        rising-edge clock
//   Reset      asynchronous active-high reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream entry valid
//   in_ready   stage can accept an entry this cycle (state-derived)
//   in_ctrl    upstream control bus
//   in_data    upstream data bus
//   out_valid  head entry valid
//   out_ready  downstream accepts head this cycle
//   out_ctrl   head control, CTRL_BUBBLE while out_valid=0
//   out_data   head data (presented regardless of out_valid)
//   occupancy  number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                    CTRL_WIDTH  = 24,
  parameter int                    DATA_WIDTH  = 160,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0,
  parameter bit                    CLEAR_DATA  = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  // State encoding equals the number of held entries, so occupancy is the
  // state register itself.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]            r_state;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;
  logic [DATA_WIDTH-1:0] r_skid_data;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_in_fire;
  logic       w_out_fire;
  logic [1:0] w_state_nxt;
  logic       w_main_from_in;
  logic       w_main_from_skid;
  logic       w_skid_from_in;

  // Handshake outputs depend on state only, never on same-cycle inputs.
  assign w_in_ready  = (r_state != S_TWO);
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = in_valid  & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  // Next-state and load-select decode. Flush is applied with priority in the
  // register block, so this logic only describes the normal flow.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_main_from_in = 1'b1;
          w_state_nxt    = S_ONE;
        end
      end
      S_ONE: begin
        case ({w_in_fire, w_out_fire})
          2'b11: w_main_from_in = 1'b1;   // head leaves, new entry replaces it
          2'b01: w_state_nxt    = S_EMPTY;
          2'b10: begin                    // downstream stalled: park in skid
            w_skid_from_in = 1'b1;
            w_state_nxt    = S_TWO;
          end
          default: ;
        endcase
      end
      S_TWO: begin
        // in_ready is low here, so only the drain case exists.
        if (w_out_fire) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;     // unreachable encoding recovers
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_EMPTY;
      r_main_ctrl <= CTRL_BUBBLE;
      r_main_data <= '0;
      r_skid_ctrl <= CTRL_BUBBLE;
      r_skid_data <= '0;
    end else if (flush) begin
      // Squash overrides any simultaneous in_fire / out_fire; an accepted
      // input on this edge is discarded.
      r_state     <= S_EMPTY;
      r_main_ctrl <= CTRL_BUBBLE;
      r_skid_ctrl <= CTRL_BUBBLE;
      if (CLEAR_DATA) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_main_from_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_main_from_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_skid_from_in) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = w_out_valid ? r_main_ctrl : CTRL_BUBBLE;
  assign out_data  = r_main_data;
  assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int CW = 24;
  localparam int DW = 160;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  // dut clears data on flush, dut0 keeps it
  logic          in_ready, out_valid, in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl, out_ctrl0;
  logic [DW-1:0] out_data, out_data0;
  logic [1:0]    occupancy, occupancy0;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pipe_stage_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .CTRL_BUBBLE('0), .CLEAR_DATA(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy));

  pipe_stage_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .CTRL_BUBBLE('0), .CLEAR_DATA(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occupancy0));

  typedef struct {
    logic          iv, ordy, fl;
    logic [15:0]   ival;      // used as both ctrl and data payload
    logic          ov, ir;
    logic [1:0]    occ;
    logic [15:0]   ctrl, d1, d0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [15:0] ival,
                              logic ov, logic ir, logic [1:0] occ,
                              logic [15:0] ctrl, logic [15:0] d1, logic [15:0] d0);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.ival = ival;
    v.ov = ov; v.ir = ir; v.occ = occ; v.ctrl = ctrl; v.d1 = d1; v.d0 = d0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_both(input string tag, input logic ov, input logic ir, input logic [1:0] occ,
                          input logic [15:0] ctrl, input logic [15:0] d1, input logic [15:0] d0);
    chk({tag, ".out_valid"},  DW'(out_valid),  DW'(ov));
    chk({tag, ".in_ready"},   DW'(in_ready),   DW'(ir));
    chk({tag, ".occupancy"},  DW'(occupancy),  DW'(occ));
    chk({tag, ".out_ctrl"},   DW'(out_ctrl),   DW'(ctrl));
    chk({tag, ".out_data"},   out_data,        DW'(d1));
    chk({tag, ".out_valid0"}, DW'(out_valid0), DW'(ov));
    chk({tag, ".in_ready0"},  DW'(in_ready0),  DW'(ir));
    chk({tag, ".occupancy0"}, DW'(occupancy0), DW'(occ));
    chk({tag, ".out_ctrl0"},  DW'(out_ctrl0),  DW'(ctrl));
    chk({tag, ".out_data0"},  out_data0,       DW'(d0));
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [15:0] val);
    in_valid = iv; out_ready = ordy; flush = fl;
    in_ctrl = CW'(val); in_data = DW'(val);
  endtask

  initial begin
    // pass-through 1..8, one cycle late, occupancy 1
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1, 1, 0, 16'(i), 1, 1, 2'd1, 16'(i), 16'(i), 16'(i)));
    vecs.push_back(mk(0, 1, 0, 16'h0,  0, 1, 2'd0, 16'h0,  16'h8,  16'h8));
    // backpressure A, B, C held upstream, then ordered drain
    vecs.push_back(mk(1, 0, 0, 16'h11, 1, 1, 2'd1, 16'h11, 16'h11, 16'h11));
    vecs.push_back(mk(1, 0, 0, 16'h22, 1, 0, 2'd2, 16'h11, 16'h11, 16'h11));
    vecs.push_back(mk(1, 0, 0, 16'h33, 1, 0, 2'd2, 16'h11, 16'h11, 16'h11));
    vecs.push_back(mk(1, 1, 0, 16'h33, 1, 1, 2'd1, 16'h22, 16'h22, 16'h22));
    vecs.push_back(mk(1, 1, 0, 16'h33, 1, 1, 2'd1, 16'h33, 16'h33, 16'h33));
    vecs.push_back(mk(0, 1, 0, 16'h0,  0, 1, 2'd0, 16'h0,  16'h33, 16'h33));
    // simultaneous in/out at ONE, then stable hold, then drain
    vecs.push_back(mk(1, 0, 0, 16'h44, 1, 1, 2'd1, 16'h44, 16'h44, 16'h44));
    vecs.push_back(mk(1, 1, 0, 16'h45, 1, 1, 2'd1, 16'h45, 16'h45, 16'h45));
    vecs.push_back(mk(0, 0, 0, 16'h0,  1, 1, 2'd1, 16'h45, 16'h45, 16'h45));
    vecs.push_back(mk(0, 1, 0, 16'h0,  0, 1, 2'd0, 16'h0,  16'h45, 16'h45));
    // flush collision at ONE: B discarded, next load is D not B
    vecs.push_back(mk(1, 0, 0, 16'h55, 1, 1, 2'd1, 16'h55, 16'h55, 16'h55));
    vecs.push_back(mk(1, 0, 1, 16'h66, 0, 1, 2'd0, 16'h0,  16'h0,  16'h55));
    vecs.push_back(mk(0, 1, 0, 16'h0,  0, 1, 2'd0, 16'h0,  16'h0,  16'h55));
    vecs.push_back(mk(1, 0, 0, 16'h67, 1, 1, 2'd1, 16'h67, 16'h67, 16'h67));
    vecs.push_back(mk(0, 1, 0, 16'h0,  0, 1, 2'd0, 16'h0,  16'h67, 16'h67));
    // flush from TWO, overriding out_fire
    vecs.push_back(mk(1, 0, 0, 16'h77, 1, 1, 2'd1, 16'h77, 16'h77, 16'h77));
    vecs.push_back(mk(1, 0, 0, 16'h88, 1, 0, 2'd2, 16'h77, 16'h77, 16'h77));
    vecs.push_back(mk(0, 1, 1, 16'h0,  0, 1, 2'd0, 16'h0,  16'h0,  16'h77));
    vecs.push_back(mk(0, 0, 0, 16'h0,  0, 1, 2'd0, 16'h0,  16'h0,  16'h77));

    // reset state before any clock edge
    Reset = 1'b1;
    drive(0, 0, 0, 16'h0);
    #1;
    chk_both("reset", 0, 1, 2'd0, 16'h0, 16'h0, 16'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ival);
      @(posedge Clk);
      #1;
      chk_both($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].occ,
               vecs[i].ctrl, vecs[i].d1, vecs[i].d0);
    end

    // reset asserted between edges while full
    drive(1, 0, 0, 16'h91);
    @(posedge Clk); #1;
    drive(1, 0, 0, 16'h92);
    @(posedge Clk); #1;
    chk_both("fill_two", 1, 0, 2'd2, 16'h91, 16'h91, 16'h91);
    #2;
    Reset = 1'b1;
    #1;
    chk_both("mid_reset", 0, 1, 2'd0, 16'h0, 16'h0, 16'h0);
    @(negedge Clk);
    Reset = 1'b0;
    drive(1, 0, 0, 16'h93);
    @(posedge Clk); #1;
    chk_both("post_reset", 1, 1, 2'd1, 16'h93, 16'h93, 16'h93);
    drive(0, 1, 0, 16'h0);
    @(posedge Clk); #1;
    chk_both("post_drain", 0, 1, 2'd0, 16'h0, 16'h93, 16'h93);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the pipelined datapath, the successor to the fixed-field stage registers between IF/ID/EX/MEM/WB. It carries one packed control bus and one packed data bus per stage and uses a valid/ready handshake, so a downstream stall never drops an instruction. A 2-entry skid buffer keeps throughput at 1 per cycle with a registered in_ready. A synchronous flush squashes the stage to a bubble.

Parameters:
CTRL_WIDTH, 24, width of packed control bus (RegWrite, MemWrite, ALUOp, ...).
DATA_WIDTH, 160, width of packed data bus (PC+4, read data, sign-extended immediate, register fields, ...).
CTRL_BUBBLE, 0, control value presented when the stage is empty, flushed or reset; must encode "no side effects".
CLEAR_DATA, 1, 1 = flush/reset zero stored data; 0 = flush leaves data contents unchanged.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous active-high reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle (registered)
in_ctrl  in  CTRL_WIDTH  upstream control
in_data  in  DATA_WIDTH  upstream data
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head this cycle
out_ctrl  out  CTRL_WIDTH  head control; CTRL_BUBBLE when out_valid=0
out_data  out  DATA_WIDTH  head data
occupancy  out  2  number of held entries (0..2)

Behaviour:
- Storage: main entry (head) and skid entry, each {ctrl, data}. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States EMPTY (occupancy 0), ONE (1), TWO (2). All outputs are registered or depend only on state.
- EMPTY: in_fire -> main <= in, go to ONE. Otherwise stay.
- ONE: in_fire & out_fire -> main <= in, stay ONE. out_fire only -> EMPTY. in_fire only -> skid <= in, go to TWO. Neither -> hold.
- TWO: in_ready=0, so no in_fire. out_fire -> main <= skid, go to ONE. Otherwise hold.
- in_ready = (state != TWO). out_valid = (state != EMPTY).
- out_ctrl = main.ctrl when out_valid, else CTRL_BUBBLE. out_data = main.data regardless of out_valid.
- Latency: an entry accepted at edge N appears on out_* after edge N when the stage was EMPTY or draining. Sustained throughput is 1 entry per cycle. Order is strictly FIFO.
- flush=1 at an edge: state -> EMPTY; main.ctrl and skid.ctrl <= CTRL_BUBBLE; data <= 0 if CLEAR_DATA=1.
- flush overrides any simultaneous in_fire, which is discarded (upstream sees the handshake complete). It also overrides out_fire.
- After a flush edge: in_ready=1, out_valid=0.
- Reset=1: immediately, without waiting for Clk, state=EMPTY, in_ready=1, out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, occupancy=0, both entries ctrl=CTRL_BUBBLE, data=0.
- Reset asserted mid-transfer drops all held entries. First edge after deassertion behaves as EMPTY.
- out_ready while out_valid=0 has no effect. in_* values are don't-care while in_valid=0.
- Stable hold: while out_valid=1 and out_ready=0, out_ctrl/out_data remain unchanged.

Test Plan:
- Reset mid-run: fill to TWO, assert Reset between edges -> out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, out_data=0 before the next edge.
- Pass-through: out_ready=1, in_valid=1 for 8 cycles, data=1..8 -> out_data=1..8 on consecutive cycles, one cycle late; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0, send A=0x11, B=0x22 -> occupancy=2, in_ready=0, C held upstream. Raise out_ready -> A, B, C emerge in order with no loss or duplicate.
- Flush collision: state ONE holding A, flush=1 with in_valid=1 carrying B -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0; B never appears.
- Flush from TWO with CLEAR_DATA=0 -> occupancy=0, out_ctrl=CTRL_BUBBLE, out_data retains A; with CLEAR_DATA=1 -> out_data=0.
- Simultaneous in/out at ONE: head A, out_ready=1, in B -> next cycle head=B, occupancy=1; no entry enters skid.
